// File: rtl/rsa256_wrapper.sv
`default_nettype none
// ============================================================================
//  Module  : rsa256_wrapper
//  Brief   : Feeds an RSA-256 core from a UART-style Avalon-MM byte stream.
//            Loads the keys N and D once, then for each block loads A, runs
//            the core and sends back the 31 low-order result bytes.
//  Rev     : 1.0  initial release
// ============================================================================
module rsa256_wrapper #(
    parameter int RX_ADDR   = 0,
    parameter int TX_ADDR   = 4,
    parameter int STAT_ADDR = 8,
    parameter int RX_OK_BIT = 7,
    parameter int TX_OK_BIT = 6,
    parameter int OUT_BYTES = 31
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_core_start,
    output logic [255:0] o_core_n,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_a,
    input  logic [255:0] i_core_result,
    input  logic         i_core_finished,
    output logic         o_key_loaded
);

    localparam logic [4:0] c_RX_ADDR   = RX_ADDR[4:0];
    localparam logic [4:0] c_TX_ADDR   = TX_ADDR[4:0];
    localparam logic [4:0] c_STAT_ADDR = STAT_ADDR[4:0];
    localparam logic [5:0] c_OUT_BYTES = OUT_BYTES[5:0];
    localparam logic [5:0] c_KEY_BYTES = 6'd32;

    typedef enum logic [2:0] {
        S_Q_RX  = 3'd0,
        S_RD    = 3'd1,
        S_START = 3'd2,
        S_CALC  = 3'd3,
        S_Q_TX  = 3'd4,
        S_WR    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_LOAD_N = 2'd0,
        PH_LOAD_D = 2'd1,
        PH_LOAD_A = 2'd2
    } phase_t;

    state_t        r_state, w_state;
    phase_t        r_phase, w_phase;
    logic [5:0]    r_cnt, w_cnt;
    logic [255:0]  r_n, w_n;
    logic [255:0]  r_d, w_d;
    logic [255:0]  r_a, w_a;
    logic [255:0]  r_res, w_res;
    logic          r_read, w_read;
    logic          r_write, w_write;
    logic [4:0]    r_addr, w_addr;
    logic [7:0]    r_wdata, w_wdata;
    logic          r_start, w_start;
    logic          r_key_loaded, w_key_loaded;

    logic          w_rd_done;
    logic          w_wr_done;
    logic [5:0]    w_cnt_inc;
    logic          w_unused;

    assign w_rd_done = r_read && !avm_waitrequest;
    assign w_wr_done = r_write && !avm_waitrequest;
    assign w_cnt_inc = r_cnt + 6'd1;
    assign w_unused  = ^avm_readdata[31:8];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_Q_RX;
            r_phase      <= PH_LOAD_N;
            r_cnt        <= '0;
            r_n          <= '0;
            r_d          <= '0;
            r_a          <= '0;
            r_res        <= '0;
            r_read       <= 1'b1;
            r_write      <= 1'b0;
            r_addr       <= c_STAT_ADDR;
            r_wdata      <= '0;
            r_start      <= 1'b0;
            r_key_loaded <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_phase      <= w_phase;
            r_cnt        <= w_cnt;
            r_n          <= w_n;
            r_d          <= w_d;
            r_a          <= w_a;
            r_res        <= w_res;
            r_read       <= w_read;
            r_write      <= w_write;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_start      <= w_start;
            r_key_loaded <= w_key_loaded;
        end
    end

    // Bus request/address/data only move on a completed transfer, so they
    // stay frozen for as long as the peripheral stalls.
    always_comb begin
        w_state      = r_state;
        w_phase      = r_phase;
        w_cnt        = r_cnt;
        w_n          = r_n;
        w_d          = r_d;
        w_a          = r_a;
        w_res        = r_res;
        w_read       = r_read;
        w_write      = r_write;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_start      = 1'b0;
        w_key_loaded = r_key_loaded;

        case (r_state)
            S_Q_RX: begin
                if (w_rd_done && avm_readdata[RX_OK_BIT]) begin
                    w_state = S_RD;
                    w_addr  = c_RX_ADDR;
                end
            end
            S_RD: begin
                if (w_rd_done) begin
                    case (r_phase)
                        PH_LOAD_N: w_n = {r_n[247:0], avm_readdata[7:0]};
                        PH_LOAD_D: w_d = {r_d[247:0], avm_readdata[7:0]};
                        default:   w_a = {r_a[247:0], avm_readdata[7:0]};
                    endcase
                    w_addr  = c_STAT_ADDR;
                    w_state = S_Q_RX;
                    w_cnt   = w_cnt_inc;
                    if (w_cnt_inc == c_KEY_BYTES) begin
                        w_cnt = '0;
                        case (r_phase)
                            PH_LOAD_N: w_phase = PH_LOAD_D;
                            PH_LOAD_D: begin
                                w_phase      = PH_LOAD_A;
                                w_key_loaded = 1'b1;
                            end
                            default: begin
                                w_state = S_START;
                                w_read  = 1'b0;
                                w_start = 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_START: begin
                w_state = S_CALC;
            end
            S_CALC: begin
                if (i_core_finished) begin
                    w_res   = i_core_result;
                    w_state = S_Q_TX;
                    w_read  = 1'b1;
                    w_addr  = c_STAT_ADDR;
                end
            end
            S_Q_TX: begin
                if (w_rd_done && avm_readdata[TX_OK_BIT]) begin
                    w_state = S_WR;
                    w_read  = 1'b0;
                    w_write = 1'b1;
                    w_addr  = c_TX_ADDR;
                    w_wdata = r_res[247:240];
                end
            end
            S_WR: begin
                if (w_wr_done) begin
                    w_res   = {r_res[247:0], 8'h00};
                    w_write = 1'b0;
                    w_read  = 1'b1;
                    w_addr  = c_STAT_ADDR;
                    // Top byte of the result is never sent: 31 bytes per block.
                    if (w_cnt_inc == c_OUT_BYTES) begin
                        w_cnt   = '0;
                        w_state = S_Q_RX;
                    end else begin
                        w_cnt   = w_cnt_inc;
                        w_state = S_Q_TX;
                    end
                end
            end
            default: begin
                w_state = S_Q_RX;
                w_read  = 1'b1;
                w_write = 1'b0;
                w_addr  = c_STAT_ADDR;
            end
        endcase
    end

    assign avm_address   = r_addr;
    assign avm_read      = r_read;
    assign avm_write     = r_write;
    assign avm_writedata = {24'h000000, r_wdata};
    assign o_core_start  = r_start;
    assign o_core_n      = r_n;
    assign o_core_d      = r_d;
    assign o_core_a      = r_a;
    assign o_key_loaded  = r_key_loaded;

endmodule
`default_nettype wire
